// File: rtl/reorder_buffer_pkg.sv
// Shared reorder-buffer definitions: sizes, entry layout and instruction type codes.
// Imported by the ROB, its bus interface, the reservation station and the LSB.
package reorder_buffer_pkg;
  localparam int ROB_WIDTH = 3;
  localparam int ROB_SIZE  = 2 ** ROB_WIDTH;
  localparam int RS_WIDTH  = 3;
  localparam int LSB_WIDTH = 3;

  typedef logic [ROB_WIDTH-1:0] rob_id_t;

  typedef enum logic [1:0] {
    INST_ALU    = 2'd0,
    INST_LOAD   = 2'd1,
    INST_STORE  = 2'd2,
    INST_BRANCH = 2'd3
  } inst_type_e;

  typedef struct packed {
    logic        busy;
    logic        ready;
    logic [4:0]  rd;
    logic        is_branch;
    logic        pred_taken;
    logic [31:0] alt_pc;
    logic [31:0] data;
  } rob_entry_t;

  // A branch resolves against its prediction through bit 0 of its result.
  function automatic logic is_mispredict(input rob_entry_t e);
    return e.is_branch && (e.data[0] != e.pred_taken);
  endfunction
endpackage

// File: rtl/reorder_buffer_if.sv
// Issue / writeback / query / commit bus between the ROB and its neighbours.
// master = decoder, RS, LSB and register-file side; slave = the ROB.
interface reorder_buffer_if;
  import reorder_buffer_pkg::*;

  logic        issue_en;
  logic [4:0]  issue_rd;
  logic        issue_is_branch;
  logic        issue_pred_taken;
  logic [31:0] issue_alt_pc;
  rob_id_t     issue_rob_id;
  logic        full;

  logic        rs_en;
  logic        rs_rdy;
  rob_id_t     rs_rob_id;
  logic [31:0] rs_data;
  logic        lsb_en;
  rob_id_t     lsb_rob_id;
  logic [31:0] lsb_data;

  rob_id_t     qry_j_id;
  rob_id_t     qry_k_id;
  logic        qry_j_ready;
  logic        qry_k_ready;
  logic [31:0] qry_j_data;
  logic [31:0] qry_k_data;

  logic        commit_en;
  logic [4:0]  commit_rd;
  logic [31:0] commit_data;
  rob_id_t     commit_rob_id;
  logic        flush;
  logic [31:0] flush_pc;

  modport master (
    output issue_en, issue_rd, issue_is_branch, issue_pred_taken, issue_alt_pc,
    output rs_en, rs_rob_id, rs_data, lsb_en, lsb_rob_id, lsb_data,
    output qry_j_id, qry_k_id,
    input  issue_rob_id, full, rs_rdy,
    input  qry_j_ready, qry_k_ready, qry_j_data, qry_k_data,
    input  commit_en, commit_rd, commit_data, commit_rob_id, flush, flush_pc
  );

  modport slave (
    input  issue_en, issue_rd, issue_is_branch, issue_pred_taken, issue_alt_pc,
    input  rs_en, rs_rob_id, rs_data, lsb_en, lsb_rob_id, lsb_data,
    input  qry_j_id, qry_k_id,
    output issue_rob_id, full, rs_rdy,
    output qry_j_ready, qry_k_ready, qry_j_data, qry_k_data,
    output commit_en, commit_rd, commit_data, commit_rob_id, flush, flush_pc
  );
endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order retirement buffer: allocates on issue, collects RS/LSB results,
// retires the head entry when ready and flushes everything on a mispredicted branch.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  reorder_buffer_if.slave  rob_bus
);
  localparam logic [ROB_WIDTH:0] CNT_FULL = (ROB_WIDTH + 1)'(ROB_SIZE);
  localparam logic [ROB_WIDTH:0] CNT_ONE  = (ROB_WIDTH + 1)'(1);
  localparam rob_id_t            ID_ONE   = rob_id_t'(1);

  rob_entry_t         r_entries [ROB_SIZE];
  rob_id_t            r_head;
  rob_id_t            r_tail;
  logic [ROB_WIDTH:0] r_count;
  logic               r_commit_en;
  logic [4:0]         r_commit_rd;
  logic [31:0]        r_commit_data;
  rob_id_t            r_commit_rob_id;
  logic               r_flush;
  logic [31:0]        r_flush_pc;

  rob_entry_t         w_head;
  rob_entry_t         w_new_entry;
  logic               w_full;
  logic               w_commit;
  logic               w_mispredict;
  logic               w_issue;
  logic [ROB_WIDTH:0] w_count_next;
  logic               w_qry_j_ready;
  logic               w_qry_k_ready;
  logic [31:0]        w_qry_j_data;
  logic [31:0]        w_qry_k_data;

  assign w_head       = r_entries[r_head];
  assign w_full       = (r_count == CNT_FULL);
  assign w_commit     = w_head.busy && w_head.ready;
  assign w_mispredict = w_commit && is_mispredict(w_head);
  // Full comes from the registered count, so a same-cycle retirement never frees room.
  assign w_issue      = rob_bus.issue_en && !w_full && !r_flush;

  assign w_new_entry = '{busy: 1'b1, ready: 1'b0, rd: rob_bus.issue_rd,
                         is_branch: rob_bus.issue_is_branch,
                         pred_taken: rob_bus.issue_pred_taken,
                         alt_pc: rob_bus.issue_alt_pc, data: 32'd0};

  // Occupancy after this cycle's allocation and retirement.
  always_comb begin
    w_count_next = r_count;
    case ({w_issue, w_commit})
      2'b10:   w_count_next = r_count + CNT_ONE;
      2'b01:   w_count_next = r_count - CNT_ONE;
      default: w_count_next = r_count;
    endcase
  end

  // Operand j lookup with same-cycle writeback bypass (RS over LSB).
  always_comb begin
    w_qry_j_ready = 1'b0;
    w_qry_j_data  = 32'd0;
    if (!r_entries[rob_bus.qry_j_id].busy) begin
      w_qry_j_ready = 1'b0;
      w_qry_j_data  = 32'd0;
    end else if (rob_bus.rs_en && (rob_bus.rs_rob_id == rob_bus.qry_j_id)) begin
      w_qry_j_ready = 1'b1;
      w_qry_j_data  = rob_bus.rs_data;
    end else if (rob_bus.lsb_en && (rob_bus.lsb_rob_id == rob_bus.qry_j_id)) begin
      w_qry_j_ready = 1'b1;
      w_qry_j_data  = rob_bus.lsb_data;
    end else begin
      w_qry_j_ready = r_entries[rob_bus.qry_j_id].ready;
      w_qry_j_data  = r_entries[rob_bus.qry_j_id].data;
    end
  end

  // Operand k lookup with same-cycle writeback bypass (RS over LSB).
  always_comb begin
    w_qry_k_ready = 1'b0;
    w_qry_k_data  = 32'd0;
    if (!r_entries[rob_bus.qry_k_id].busy) begin
      w_qry_k_ready = 1'b0;
      w_qry_k_data  = 32'd0;
    end else if (rob_bus.rs_en && (rob_bus.rs_rob_id == rob_bus.qry_k_id)) begin
      w_qry_k_ready = 1'b1;
      w_qry_k_data  = rob_bus.rs_data;
    end else if (rob_bus.lsb_en && (rob_bus.lsb_rob_id == rob_bus.qry_k_id)) begin
      w_qry_k_ready = 1'b1;
      w_qry_k_data  = rob_bus.lsb_data;
    end else begin
      w_qry_k_ready = r_entries[rob_bus.qry_k_id].ready;
      w_qry_k_data  = r_entries[rob_bus.qry_k_id].data;
    end
  end

  // Entry table, pointers and registered commit/flush outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < ROB_SIZE; i++) r_entries[i] <= '0;
      r_head          <= '0;
      r_tail          <= '0;
      r_count         <= '0;
      r_commit_en     <= 1'b0;
      r_commit_rd     <= 5'd0;
      r_commit_data   <= 32'd0;
      r_commit_rob_id <= '0;
      r_flush         <= 1'b0;
      r_flush_pc      <= 32'd0;
    end else if (rdy_in) begin
      r_commit_en <= w_commit;
      r_flush     <= w_mispredict;
      if (w_commit) begin
        r_commit_rd     <= w_head.is_branch ? 5'd0 : w_head.rd;
        r_commit_data   <= w_head.data;
        r_commit_rob_id <= r_head;
      end
      if (w_mispredict) begin
        // Wrong-path state, including this cycle's issue and writebacks, is dropped.
        r_flush_pc <= w_head.alt_pc;
        for (int i = 0; i < ROB_SIZE; i++) r_entries[i] <= '0;
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (rob_bus.lsb_en && r_entries[rob_bus.lsb_rob_id].busy) begin
          r_entries[rob_bus.lsb_rob_id].ready <= 1'b1;
          r_entries[rob_bus.lsb_rob_id].data  <= rob_bus.lsb_data;
        end
        if (rob_bus.rs_en && r_entries[rob_bus.rs_rob_id].busy) begin
          r_entries[rob_bus.rs_rob_id].ready <= 1'b1;
          r_entries[rob_bus.rs_rob_id].data  <= rob_bus.rs_data;
        end
        if (w_issue) begin
          r_entries[r_tail] <= w_new_entry;
          r_tail            <= r_tail + ID_ONE;
        end
        if (w_commit) begin
          r_entries[r_head].busy  <= 1'b0;
          r_entries[r_head].ready <= 1'b0;
          r_head                  <= r_head + ID_ONE;
        end
        r_count <= w_count_next;
      end
    end else begin
      r_commit_en <= 1'b0;
      r_flush     <= 1'b0;
    end
  end

  assign rob_bus.issue_rob_id  = r_tail;
  assign rob_bus.full          = w_full;
  assign rob_bus.rs_rdy        = 1'b1;
  assign rob_bus.qry_j_ready   = w_qry_j_ready;
  assign rob_bus.qry_j_data    = w_qry_j_data;
  assign rob_bus.qry_k_ready   = w_qry_k_ready;
  assign rob_bus.qry_k_data    = w_qry_k_data;
  assign rob_bus.commit_en     = r_commit_en;
  assign rob_bus.commit_rd     = r_commit_rd;
  assign rob_bus.commit_data   = r_commit_data;
  assign rob_bus.commit_rob_id = r_commit_rob_id;
  assign rob_bus.flush         = r_flush;
  assign rob_bus.flush_pc      = r_flush_pc;
endmodule
